disparity_engine: RTL
=====================

DISPARITY_ENGINE -- requirements
Module: disparity_engine

Interface
REQ-001 SHALL have parameter PIX_W, 9, pixel width in bits.
REQ-002 SHALL have parameter ROW_LEN, 800, pixels per row; a multiple of WIN and >= 2*WIN.
REQ-003 SHALL have parameter WIN, 4, matching-block width in pixels; one of 2, 4 or 8.
REQ-004 SHALL have parameter MAX_DISP, 10, number of candidate disparities 0..MAX_DISP-1; range 2..16.
REQ-005 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports i_valid_l and i_valid_r, input, 1, left/right pixel strobes; each is a transfer when high with o_in_ready high.
REQ-008 SHALL have ports i_data_l and i_data_r, input, PIX_W, left/right pixels.
REQ-009 SHALL have port o_in_ready, output, 1, high only in FETCH.
REQ-010 SHALL have port i_out_ready, input, 1, downstream backpressure.
REQ-011 SHALL have port o_valid, output, 1, result pixel present.
REQ-012 SHALL have port o_disp, output, 5, disparity of the current result pixel.
REQ-013 SHALL have ports o_data_R, o_data_G and o_data_B, output, 10 each, pixel colour.

Function
REQ-014 SHALL cycle through the states IDLE -> FETCH -> CALC -> OUTPUT -> FETCH; IDLE exits to FETCH on the first cycle after reset release.
REQ-015 FETCH SHALL store transferred left and right pixels in two independent ROW_LEN buffers with separate write counters; the left and right streams may arrive on any cycles, including simultaneously.
REQ-016 A transfer on a side whose counter equals ROW_LEN SHALL be ignored; FETCH SHALL go to CALC on the cycle after both counters reach ROW_LEN, then clear both counters.
REQ-017 CALC SHALL process the row as blocks of WIN pixels starting at x = 0, WIN, 2*WIN, and so on, evaluating one candidate d per cycle for d = 0 up to MAX_DISP-1.
REQ-018 For each candidate, SAD SHALL be the sum over k = 0..WIN-1 of |R[x+k] - L[x+k+d]|.
REQ-019 The SAD SHALL use PIX_W+log2(WIN) bits with unsigned true absolute difference and no wrap.
REQ-020 A candidate with x+d+WIN-1 >= ROW_LEN SHALL be invalid and never selected.
REQ-021 The selected disparity SHALL be the valid candidate with the minimum SAD; on a tie the smaller d wins; d = 0 is always valid.
REQ-022 On the cycle after the last candidate, the selected d SHALL be written to all WIN result entries of the block and the minimum tracker SHALL reload to all-ones; each block therefore takes MAX_DISP+1 cycles.
REQ-023 After the final block, the state SHALL become OUTPUT.
REQ-024 OUTPUT SHALL stream ROW_LEN result pixels in order, x = 0 first, presenting o_valid=1 and holding o_disp/o_data stable until a cycle where i_out_ready=1.
REQ-025 After the ROW_LEN-th accepted result, OUTPUT SHALL drop o_valid and return to FETCH on the next cycle.
REQ-026 o_valid SHALL be 0 in all states other than OUTPUT.
REQ-027 While o_valid=0, o_disp and o_data_R/G/B SHALL be 0.

Reset
REQ-028 Asserting rst SHALL, without waiting for a clock edge, set the state to IDLE, clear all counters, set the minimum trackers to all-ones, and drive o_valid=0, o_in_ready=0 and o_disp=o_data_*=0.
REQ-029 Reset asserted mid-row in any state SHALL abandon the row; no partial result is output afterwards.
REQ-030 Row and result buffer contents SHALL need no reset.

Configuration
REQ-031 With DISP_COLOR_EN defined, o_data_R/G/B SHALL map the disparity through this colour table: 0=(255,0,0); 1=(255,64,0); 2=(255,136,0); 3=(255,221,0); 4=(153,255,0); 5=(26,255,0); 6=(0,255,162); 7=(0,212,255); 8=(0,98,255); 9=(47,0,255); any disparity >= 10 = (255,255,255).
REQ-032 Without DISP_COLOR_EN, o_data_R, o_data_G and o_data_B SHALL each equal o_disp zero-extended, giving greyscale output with no colour-table logic.

Verification (ROW_LEN=16, WIN=4, MAX_DISP=4, DISP_COLOR_EN defined)
REQ-033 The bench SHALL drive R[i]=i*10 and L[i]=R[i-2] (L[0..1]=0) -> require o_disp=2 for x=0..11, and for x=12..15 only d 0..0 valid so o_disp=0.
REQ-034 The bench SHALL drive constant L=R=100 -> all SADs tie, so require o_disp=0 and RGB=(255,0,0) on all 16 outputs.
REQ-035 The bench SHALL drive left pixels all on cycles 0..15 and right pixels on alternate cycles -> require CALC entered exactly one cycle after the 16th right transfer and extra i_valid_l pulses ignored.
REQ-036 The bench SHALL hold i_out_ready=0 for 5 cycles during OUTPUT at x=3 -> require o_valid=1 with o_disp for x=3 held constant, then exactly 16 accepted outputs.
REQ-037 The bench SHALL pulse rst during CALC block 2 -> require o_valid=0 immediately, then a fresh row to produce correct results with no stale outputs.
REQ-038 The bench SHALL run with DISP_COLOR_EN undefined and the REQ-033 stimulus -> require R=G=B=2 for x=0..11.

Source files
------------

// File: rtl/disparity_engine.sv
// disparity_engine
//   Row-based stereo block matcher. A left and a right row of ROW_LEN pixels
//   are captured independently. Each WIN-wide block of the right row is then
//   matched against the left row shifted by d = 0..MAX_DISP-1 using SAD. The
//   winning disparity per pixel is streamed out with valid/ready handshaking.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous active-high reset
//   i_valid_l, i_data_l   left pixel strobe / pixel
//   i_valid_r, i_data_r   right pixel strobe / pixel
//   o_in_ready            high while capturing a row (FETCH)
//   i_out_ready           downstream accepts the current result
//   o_valid               result pixel present (OUTPUT only)
//   o_disp                disparity of the current result pixel
//   o_data_R/G/B          pixel colour (10 bits each)
//
// Build option
//   DISP_COLOR_EN  defined: disparity drives a colour table;
//                  undefined: R = G = B = o_disp (greyscale).
module disparity_engine #(
   parameter int PIX_W    = 9,
   parameter int ROW_LEN  = 800,
   parameter int WIN      = 4,
   parameter int MAX_DISP = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid_l,
   input  logic             i_valid_r,
   input  logic [PIX_W-1:0] i_data_l,
   input  logic [PIX_W-1:0] i_data_r,
   output logic             o_in_ready,
   input  logic             i_out_ready,
   output logic             o_valid,
   output logic [4:0]       o_disp,
   output logic [9:0]       o_data_R,
   output logic [9:0]       o_data_G,
   output logic [9:0]       o_data_B
);
   localparam int SAD_W = PIX_W + $clog2(WIN);
   localparam int CNT_W = $clog2(ROW_LEN + 1);
   localparam int IDX_W = $clog2(ROW_LEN);
   localparam int D_W   = $clog2(MAX_DISP + 1);

   typedef enum logic [1:0] {IDLE, FETCH, CALC, OUTPUT} state_t;

   state_t           state, state_nxt;
   logic [PIX_W-1:0] row_l [ROW_LEN];
   logic [PIX_W-1:0] row_r [ROW_LEN];
   logic [4:0]       res   [ROW_LEN];

   logic [CNT_W-1:0] cnt_l, cnt_r, cnt_l_nxt, cnt_r_nxt;
   logic [CNT_W-1:0] blk_x, out_x;
   logic [D_W-1:0]   cand;
   logic [SAD_W-1:0] sad, min_sad;
   logic [4:0]       best_d;
   logic             take_l, take_r, row_done, cand_ok, blk_end, last_blk, last_out;

   function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // A side that already holds a full row ignores further strobes.
   assign o_in_ready = (state == FETCH);
   assign take_l     = o_in_ready && i_valid_l && (cnt_l != CNT_W'(ROW_LEN));
   assign take_r     = o_in_ready && i_valid_r && (cnt_r != CNT_W'(ROW_LEN));
   assign cnt_l_nxt  = cnt_l + CNT_W'(take_l);
   assign cnt_r_nxt  = cnt_r + CNT_W'(take_r);
   // Leave FETCH on the edge that completes the second row.
   assign row_done   = o_in_ready && (cnt_l_nxt == CNT_W'(ROW_LEN)) &&
                       (cnt_r_nxt == CNT_W'(ROW_LEN));

   // The extra cycle after the last candidate commits the block.
   assign blk_end  = (cand == D_W'(MAX_DISP));
   assign last_blk = (blk_x == CNT_W'(ROW_LEN - WIN));
   assign last_out = (out_x == CNT_W'(ROW_LEN - 1));

   // SAD for the current candidate. Left reads beyond the row are redirected
   // to a legal address; such candidates are flagged invalid anyway.
   always_comb begin
      int xr, xl;
      sad     = '0;
      xr      = 0;
      xl      = 0;
      cand_ok = (int'(blk_x) + int'(cand) + WIN - 1) < ROW_LEN;
      for (int k = 0; k < WIN; k++) begin
         xr = int'(blk_x) + k;
         xl = xr + int'(cand);
         if (xl >= ROW_LEN) xl = xr;
         sad = sad + SAD_W'(abs_diff(row_r[IDX_W'(xr)], row_l[IDX_W'(xl)]));
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (row_done) state_nxt = CALC;
         CALC:    if (blk_end && last_blk) state_nxt = OUTPUT;
         OUTPUT:  if (i_out_ready && last_out) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt_l   <= '0;
         cnt_r   <= '0;
         blk_x   <= '0;
         cand    <= '0;
         out_x   <= '0;
         min_sad <= '1;
         best_d  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            FETCH: begin
               cnt_l <= row_done ? '0 : cnt_l_nxt;
               cnt_r <= row_done ? '0 : cnt_r_nxt;
            end
            CALC: begin
               if (blk_end) begin
                  cand    <= '0;
                  min_sad <= '1;
                  best_d  <= '0;
                  blk_x   <= last_blk ? '0 : blk_x + CNT_W'(WIN);
               end else begin
                  cand <= cand + 1'b1;
                  // Strict compare keeps the smaller d on a tie.
                  if (cand_ok && (sad < min_sad)) begin
                     min_sad <= sad;
                     best_d  <= 5'(cand);
                  end
               end
            end
            OUTPUT: begin
               if (i_out_ready) out_x <= last_out ? '0 : out_x + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Row and result storage carry no reset.
   always_ff @(posedge clk) begin
      if (take_l) row_l[IDX_W'(cnt_l)] <= i_data_l;
      if (take_r) row_r[IDX_W'(cnt_r)] <= i_data_r;
      if ((state == CALC) && blk_end) begin
         for (int k = 0; k < WIN; k++) res[IDX_W'(int'(blk_x) + k)] <= best_d;
      end
   end

   assign o_valid = (state == OUTPUT);
   assign o_disp  = o_valid ? res[IDX_W'(out_x)] : 5'd0;

`ifdef DISP_COLOR_EN
   function automatic logic [29:0] colour_of(input logic [4:0] d);
      case (d)
         5'd0:    return {10'd255, 10'd0,   10'd0};
         5'd1:    return {10'd255, 10'd64,  10'd0};
         5'd2:    return {10'd255, 10'd136, 10'd0};
         5'd3:    return {10'd255, 10'd221, 10'd0};
         5'd4:    return {10'd153, 10'd255, 10'd0};
         5'd5:    return {10'd26,  10'd255, 10'd0};
         5'd6:    return {10'd0,   10'd255, 10'd162};
         5'd7:    return {10'd0,   10'd212, 10'd255};
         5'd8:    return {10'd0,   10'd98,  10'd255};
         5'd9:    return {10'd47,  10'd0,   10'd255};
         default: return {10'd255, 10'd255, 10'd255};
      endcase
   endfunction

   assign {o_data_R, o_data_G, o_data_B} = o_valid ? colour_of(o_disp) : 30'd0;
`else
   assign o_data_R = {5'd0, o_disp};
   assign o_data_G = {5'd0, o_disp};
   assign o_data_B = {5'd0, o_disp};
`endif

endmodule
